// File: rtl/axil_mem_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite memory responder.
package axil_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int LAT_WIDTH = 4;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

endpackage

// File: rtl/axil_mem_array.sv
// Byte-enable RAM with one write port and one registered read port.
// A read colliding with a write to the same word returns the new bytes.
module axil_mem_array #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned STRB_W     = DATA_WIDTH / 8,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = mem[raddr_i];
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && (waddr_i == raddr_i) && wstrb_i[b]) begin
        rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-Lite slave backed by a word-addressed RAM, with independent read and
// write FSMs, programmable latency, SLVERR on out-of-range and ready stalls.
module axil_mem_responder
  import axil_mem_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            RD_LATENCY  = 2,
  parameter int unsigned            WR_LATENCY  = 0
) (
  input  logic                    aclk_i,
  input  logic                    arst_i,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic [2:0]              s_awprot_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  output logic [1:0]              s_bresp_o,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic [2:0]              s_arprot_i,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  input  logic [2:0]              stall_i
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * STRB_W);

  // ---------------- read channel ----------------
  rd_state_t               rd_state_q, rd_state_d;
  logic [LAT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0]   rd_addr, rd_off;
  logic [1:0]              rd_resp;
  logic                    ar_hs, rd_sample;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign ar_hs = s_arvalid_i & s_arready_o;
  // Zero-latency reads sample the live address on the handshake edge.
  assign rd_addr = (rd_state_q == R_IDLE) ? s_araddr_i : araddr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_resp = ({1'b0, rd_off} < MEM_BYTES) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
  assign rd_sample = ((rd_state_q == R_IDLE) && ar_hs && (RD_LATENCY == 0)) ||
                     ((rd_state_q == R_WAIT) && (rd_cnt_q == '0));

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      araddr_q   <= '0;
      rresp_q    <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      araddr_q   <= araddr_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    araddr_d   = araddr_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs) begin
        araddr_d = s_araddr_i;
        if (RD_LATENCY == 0) begin
          rd_state_d = R_RESP;
          rresp_d    = rd_resp;
        end else begin
          rd_state_d = R_WAIT;
          rd_cnt_d   = LAT_WIDTH'(RD_LATENCY - 1);
        end
      end
      R_WAIT: if (rd_cnt_q == '0) begin
        rd_state_d = R_RESP;
        rresp_d    = rd_resp;
      end else begin
        rd_cnt_d = rd_cnt_q - LAT_WIDTH'(1);
      end
      R_RESP: if (s_rready_i) begin
        rd_state_d = R_IDLE;
        rresp_d    = AXI_RESP_OKAY;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready_o = (rd_state_q == R_IDLE) & ~stall_i[2];
    s_rvalid_o  = (rd_state_q == R_RESP);
    s_rresp_o   = rresp_q;
    s_rdata_o   = (s_rvalid_o && (rresp_q == AXI_RESP_OKAY)) ? mem_rdata : '0;
  end

  // ---------------- write channel ----------------
  wr_state_t               wr_state_q, wr_state_d;
  logic [LAT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_off;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    aw_hs, w_hs, both_in, wr_in_range, wr_commit;

  assign aw_hs   = s_awvalid_i & s_awready_o;
  assign w_hs    = s_wvalid_i & s_wready_o;
  assign both_in = (aw_got_q | aw_hs) & (w_got_q | w_hs);
  // Bypass the capture registers so a zero-latency commit can use this cycle's beats.
  assign wr_addr = aw_got_q ? awaddr_q : s_awaddr_i;
  assign wr_data = w_got_q ? wdata_q : s_wdata_i;
  assign wr_strb = w_got_q ? wstrb_q : s_wstrb_i;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign wr_in_range = ({1'b0, wr_off} < MEM_BYTES);
  assign wr_commit = ((wr_state_q == W_IDLE) && both_in && (WR_LATENCY == 0)) ||
                     ((wr_state_q == W_WAIT) && (wr_cnt_q == '0));

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_awaddr_i;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_wdata_i;
          wstrb_d = s_wstrb_i;
        end
        if (both_in) begin
          if (WR_LATENCY == 0) begin
            wr_state_d = W_RESP;
            bresp_d    = wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          end else begin
            wr_state_d = W_WAIT;
            wr_cnt_d   = LAT_WIDTH'(WR_LATENCY - 1);
          end
        end
      end
      W_WAIT: if (wr_cnt_q == '0) begin
        wr_state_d = W_RESP;
        bresp_d    = wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else begin
        wr_cnt_d = wr_cnt_q - LAT_WIDTH'(1);
      end
      W_RESP: if (s_bready_i) begin
        wr_state_d = W_IDLE;
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        bresp_d    = AXI_RESP_OKAY;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready_o = (wr_state_q == W_IDLE) & ~aw_got_q & ~stall_i[0];
    s_wready_o  = (wr_state_q == W_IDLE) & ~w_got_q & ~stall_i[1];
    s_bvalid_o  = (wr_state_q == W_RESP);
    s_bresp_o   = bresp_q;
  end

  // A reset landing on the commit edge must not touch memory.
  axil_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (aclk_i),
    .we_i    (wr_commit & wr_in_range & ~arst_i),
    .waddr_i (wr_off[OFF_LSB +: IDX_W]),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .re_i    (rd_sample & ~arst_i),
    .raddr_i (rd_off[OFF_LSB +: IDX_W]),
    .rdata_o (mem_rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{s_awprot_i, s_arprot_i, rd_off, wr_off};

endmodule

// File: tb/tb_axil_mem_responder.sv
// Bench for axil_mem_responder: table of write/readback vectors plus
// hand sequences for latency, backpressure, stalls, channel ordering and reset.
module tb_axil_mem_responder;

  logic        clk, arst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  stall;

  axil_mem_responder #(
    .RD_LATENCY (2),
    .WR_LATENCY (2)
  ) dut (
    .aclk_i      (clk),
    .arst_i      (arst),
    .s_awvalid_i (awvalid),
    .s_awready_o (awready),
    .s_awaddr_i  (awaddr),
    .s_awprot_i  (3'b000),
    .s_wvalid_i  (wvalid),
    .s_wready_o  (wready),
    .s_wdata_i   (wdata),
    .s_wstrb_i   (wstrb),
    .s_bvalid_o  (bvalid),
    .s_bready_i  (bready),
    .s_bresp_o   (bresp),
    .s_arvalid_i (arvalid),
    .s_arready_o (arready),
    .s_araddr_i  (araddr),
    .s_arprot_i  (3'b000),
    .s_rvalid_o  (rvalid),
    .s_rready_i  (rready),
    .s_rdata_o   (rdata),
    .s_rresp_o   (rresp),
    .stall_i     (stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  logic [33:0] r_exp_q[$];
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_e;
  logic [1:0]  b_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // scoreboard: pop expected responses at each R/B handshake
  always @(negedge clk) begin
    if (!arst && rvalid && rready) begin
      if (r_exp_q.size() == 0) begin
        timeout("r_unexpected");
      end else begin
        r_e = r_exp_q.pop_front();
        check("r_data", rdata, r_e[31:0]);
        check("r_resp", rresp, r_e[33:32]);
      end
    end
    if (!arst && bvalid && bready) begin
      if (b_exp_q.size() == 0) begin
        timeout("b_unexpected");
      end else begin
        b_e = b_exp_q.pop_front();
        check("b_resp", bresp, b_e);
      end
    end
  end

  // driver tasks
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] eb);
    int  n;
    logic aw_hit, w_hit, aw_done, w_done;
    b_exp_q.push_back(eb);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hit) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hit)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) timeout("aw_w_handshake");
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bvalid) break;
      n++;
    end
    if (n == 50) timeout("bvalid_wait");
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic finish_read();
    int n;
    rready = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (rvalid) break;
      n++;
    end
    if (n == 50) timeout("rvalid_wait");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int  n;
    logic hit;
    r_exp_q.push_back({er, ed});
    araddr = a; arvalid = 1'b1; n = 0; hit = 1'b0;
    while (!hit && n < 50) begin
      @(negedge clk);
      hit = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!hit) timeout("ar_handshake");
    finish_read();
  endtask

  typedef struct {
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'b1111, 2'b00, 32'h1122_3344, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b1001, 2'b00, 32'hAA22_33DD, 2'b00};
    vecs[3] = '{1'b1, 32'h0000_0008, 32'h5566_7788, 4'b0000, 2'b00, 32'hAA22_33DD, 2'b00};
    vecs[4] = '{1'b1, 32'h0000_000A, 32'h0000_EE00, 4'b0010, 2'b00, 32'hAA22_EEDD, 2'b00};
    vecs[5] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 2'b00, 32'h1234_5678, 2'b00};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1111, 2'b00, 32'h0102_0304, 2'b00};
    vecs[7] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'b1111, 2'b10, 32'h0000_0000, 2'b10};
    vecs[8] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 4'b1111, 2'b10, 32'h0000_0000, 2'b10};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2'b00, 32'h0102_0304, 2'b00};

    arst = 1'b1; stall = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready",  wready,  1);
    check("rst_arready", arready, 1);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_bresp",   bresp,   0);
    check("rst_rresp",   rresp,   0);
    check("rst_rdata",   rdata,   0);
    @(posedge clk); #1;

    // table-driven write / readback
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].bresp);
      do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
    end

    // read latency and rready backpressure
    r_exp_q.push_back({2'b00, 32'hDEAD_BEEF});
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    check("lat_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_rvalid", rvalid, (k == 2));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_rvalid", rvalid, 1);
      check("hold_rdata",  rdata,  32'hDEAD_BEEF);
      check("hold_rresp",  rresp,  0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("post_r_rvalid", rvalid, 0);
    @(posedge clk); #1;

    // AR stall
    r_exp_q.push_back({2'b00, 32'hAA22_EEDD});
    stall = 3'b100; araddr = 32'h8; arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_arready", arready, 0);
      check("stall_rvalid",  rvalid,  0);
      check("stall_awready", awready, 1);
      @(posedge clk); #1;
    end
    stall = 3'b000;
    @(negedge clk);
    check("unstall_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    finish_read();

    // W three cycles ahead of AW
    b_exp_q.push_back(2'b00);
    wdata = 32'h0BAD_F00D; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check("early_w_wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("early_w_wready_low", wready, 0);
      check("early_w_bvalid",     bvalid, 0);
      @(posedge clk); #1;
    end
    awaddr = 32'hC; awvalid = 1'b1;
    @(negedge clk);
    check("late_aw_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wlat_bvalid",  bvalid,  (k == 2));
      check("wlat_awready", awready, 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("post_b_awready", awready, 1);
    check("post_b_wready",  wready,  1);
    check("post_b_bvalid",  bvalid,  0);
    @(posedge clk); #1;
    do_read(32'hC, 32'h0BAD_F00D, 2'b00);

    // reset during R_WAIT / W_WAIT, landing on the commit edge
    araddr = 32'h4; arvalid = 1'b1;
    awaddr = 32'h4; awvalid = 1'b1; wdata = 32'h9999_9999; wstrb = 4'b1111; wvalid = 1'b1;
    @(negedge clk);
    check("mid_arready", arready, 1);
    check("mid_awready", awready, 1);
    check("mid_wready",  wready,  1);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    check("mrst_rvalid",  rvalid,  0);
    check("mrst_bvalid",  bvalid,  0);
    check("mrst_arready", arready, 1);
    check("mrst_awready", awready, 1);
    check("mrst_wready",  wready,  1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst_quiet_r", rvalid, 0);
      check("mrst_quiet_b", bvalid, 0);
    end
    @(posedge clk); #1;
    do_read(32'h4, 32'hDEAD_BEEF, 2'b00);

    repeat (3) @(posedge clk);
    check("r_queue_empty", r_exp_q.size(), 0);
    check("b_queue_empty", b_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_mem_responder.md
Name: axil_mem_responder

Overview:
- Parametrised AXI4-Lite slave backing memory; drives the cache's m_* master port in benches and FPGA bring-up.
- Replaces the fixed "random data two cycles after AR" responder.
- Adds a real word-addressed store with byte strobes, programmable read/write latency, SLVERR on out-of-range addresses, and per-channel ready stalls.
- Read and write channels run independently; each has one outstanding transaction.

Parameters:
- ADDR_WIDTH, 32, AXI address width (bytes).
- DATA_WIDTH, 32, data width; power of two, ≥8.
- DEPTH_WORDS, 1024, words of storage; power of two.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH_WORDS*DATA_WIDTH/8.
- RD_LATENCY, 2, extra cycles from AR handshake to rvalid (0..15).
- WR_LATENCY, 0, extra cycles from AW+W capture to commit (0..15).

Ports:
- aclk_i  in  1  clock; all logic on rising edge.
- arst_i  in  1  reset; synchronous, active-high.
- s_awvalid_i/s_awready_o  in/out  1  AW handshake.
- s_awaddr_i  in  ADDR_WIDTH  write byte address.
- s_awprot_i  in  3  ignored.
- s_wvalid_i/s_wready_o  in/out  1  W handshake.
- s_wdata_i  in  DATA_WIDTH  write data.
- s_wstrb_i  in  DATA_WIDTH/8  byte enables.
- s_bvalid_o/s_bready_i  out/in  1  B handshake.
- s_bresp_o  out  2  write response.
- s_arvalid_i/s_arready_o  in/out  1  AR handshake.
- s_araddr_i  in  ADDR_WIDTH  read byte address.
- s_arprot_i  in  3  ignored.
- s_rvalid_o/s_rready_i  out/in  1  R handshake.
- s_rdata_o  out  DATA_WIDTH  read data.
- s_rresp_o  out  2  read response.
- stall_i  in  3  [0] forces awready low, [1] wready low, [2] arready low; combinational mask.

Interface fixed: one clock aclk_i; reset arst_i is synchronous and active-high.

Behaviour:
- Reset values:
  - awready, wready, arready = 1 (subject to stall_i).
  - bvalid, rvalid = 0; bresp, rresp = 00; rdata = 0.
  - Memory contents are not cleared by reset.
- Address decode:
  - word = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte bits ignored.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + DEPTH_WORDS*DATA_WIDTH/8.
- Read FSM:
  - R_IDLE: arready=1 & ~stall_i[2]. AR handshake latches the address; go to R_WAIT if RD_LATENCY>0, else R_RESP.
  - R_WAIT: arready=0; counter loads RD_LATENCY-1, decrements to 0, then R_RESP.
  - Entering R_RESP: memory sampled; rdata = word (or 0 plus rresp=10 SLVERR if out of range), rresp=00 otherwise.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready; on handshake go to R_IDLE with rvalid=0 the next cycle.
  - Timing: AR handshake at edge t gives rvalid from edge t+1+RD_LATENCY.
- Write FSM:
  - W_IDLE: awready and wready assert independently.
  - Each channel captures once; its ready drops after capture until the B handshake.
  - AW and W may arrive in either order or the same cycle.
  - When both are captured: go to W_WAIT (WR_LATENCY>0) or commit.
  - Commit: bytes with wstrb=1 written; wstrb=0 bytes unchanged.
  - Out-of-range: no write, bresp=10. wstrb=0 in range: no change, bresp=00.
  - W_RESP: bvalid=1 the cycle after commit; held until bready; then back to W_IDLE with both readies high.
- Simultaneous write commit and read sample of the same word: read returns the new data (write-first).
- stall_i only masks the ready outputs; it never drops a pending valid or alters FSM state. Stall rising in the same cycle as valid means no handshake that cycle.
- Reset mid-transaction: both FSMs return to IDLE; any pending commit is discarded; B/R responses are dropped.
- Latency counters are $clog2(16)=4 bits wide. Only BASE_ADDR subtraction uses full address width; no wrap-around aliasing.

Decomposition:
- Package axil_mem_pkg:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - rd_state_t {R_IDLE,R_WAIT,R_RESP}, wr_state_t {W_IDLE,W_WAIT,W_RESP}.
  - LAT_WIDTH=4.
- Sub-module axil_mem_array:
  - Synchronous single-write/single-read byte-enable RAM.
  - DEPTH_WORDS×DATA_WIDTH, write-first on address collision.
  - Instantiated once; the FSMs stay in axil_mem_responder.

Test Plan:
- RD_LATENCY=2. Write 0xDEADBEEF to 0x04 (wstrb=1111); then read 0x04 with AR handshake at edge t -> rvalid at t+3, rdata=0xDEADBEEF, rresp=00.
- Pre-load 0x11223344 at 0x08. Write 0xAABBCCDD with wstrb=1001 -> readback 0xAA2233DD, bresp=00.
- W arrives 3 cycles before AW, addr 0x0C -> wready low after capture; bvalid exactly 1+WR_LATENCY cycles after AW handshake; awready/wready high again after B handshake.
- Read at BASE_ADDR+DEPTH_WORDS*4 -> rresp=10, rdata=0. Write there -> bresp=10; word 0 unchanged.
- rready held low 5 cycles -> rvalid/rdata stable throughout. stall_i=3'b100 for 4 cycles with arvalid=1 -> no AR handshake until stall clears.
- Assert arst_i during R_WAIT and W_WAIT -> next cycle rvalid=bvalid=0 and all readies=1; a subsequent read returns prior committed data.
